dn_benes_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-shot Benes distribution network.
- Routes N lanes of DW_DATA bits through 2*log2(N)-1 levels of 2x2 switches, with a pipeline register after every level.
- Sits between the operand buffer and the PE array; distributes sparse operands to PEs with per-switch pass, cross or multicast.
- Adds valid/ready flow control with backpressure and a handshaked configuration load, so one vector is accepted per cycle.

---
 rtl/dn_benes_pipe_if.sv | 30 +++
 rtl/dn_benes_pipe.sv | 154 +++++++++++++++
 tb/tb_dn_benes_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dn_benes_pipe_if.sv
// Handshake bundle for dn_benes_pipe: vector stream in/out plus the config-load handshake.
// The master drives vectors and config; the slave (the network) returns ready, ack and routed data.
interface dn_benes_pipe_if #(
  parameter int DW_DATA = 8,
  parameter int N       = 8,
  parameter int LOG2N   = 3
);
  localparam int N_LEVELS = 2 * LOG2N - 1;

  logic                    set_en;
  logic [N_LEVELS*N-1:0]   route_signals;
  logic                    set_ack;
  logic                    in_valid;
  logic                    in_ready;
  logic [DW_DATA*N-1:0]    in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW_DATA*N-1:0]    out;
  logic                    busy;

  modport master (
    output set_en, route_signals, in_valid, in, out_ready,
    input  set_ack, in_ready, out_valid, out, busy
  );

  modport slave (
    input  set_en, route_signals, in_valid, in, out_ready,
    output set_ack, in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/dn_benes_pipe.sv
// Pipelined Benes distribution network: 2*LOG2N-1 levels of 2x2 pass/cross/multicast switches,
// one register stage per level, valid/ready flow control and a drain-then-load config handshake.
// Optional DN_BENES_XFER_CNT_EN adds a 32-bit output-transfer counter port xfer_cnt.
module dn_benes_pipe #(
  parameter int DW_DATA = 8,
  parameter int N       = 8,
  parameter int LOG2N   = 3
) (
  input  logic            clk,
  input  logic            reset,
  dn_benes_pipe_if.slave  bus
`ifdef DN_BENES_XFER_CNT_EN
  ,
  output logic [31:0]     xfer_cnt
`endif
);

  localparam int N_LEVELS = 2 * LOG2N - 1;
  localparam int N_SW     = N / 2;

  typedef logic [DW_DATA-1:0] lane_t;
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD} state_t;

  // Source position feeding destination d of the wiring after level l.
  // Early levels unshuffle (dest = even->p/2, odd->B/2+p/2), so the source is the inverse map;
  // later levels shuffle, so the source is the unshuffle map itself.
  function automatic int src_idx(input int l, input int d);
    int b;
    int base;
    int q;
    b    = (l < LOG2N - 1) ? (N >> l) : (N >> (N_LEVELS - 2 - l));
    base = d - (d % b);
    q    = d % b;
    if (l < LOG2N - 1)
      return base + ((q < b / 2) ? 2 * q : 2 * (q - b / 2) + 1);
    else
      return base + ((q % 2 == 0) ? q / 2 : b / 2 + q / 2);
  endfunction

  // Returns {lower, upper} for one 2x2 switch.
  function automatic logic [2*DW_DATA-1:0] switch2(input logic [1:0] code,
                                                   input lane_t a, input lane_t b);
    case (code)
      2'b00:   return {b, a};
      2'b01:   return {a, b};
      2'b10:   return {a, a};
      default: return {b, b};
    endcase
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_LEVELS*N-1:0] r_cfg;
  logic [N_LEVELS-1:0]   r_vld;
  lane_t                 r_data    [N_LEVELS][N];
  lane_t                 w_lvl_in  [N_LEVELS][N];
  lane_t                 w_lvl_out [N_LEVELS][N];
  logic [DW_DATA*N-1:0]  w_out;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_busy;
  logic                  w_set_ack;

  // Flow control: a full output stage that is not being taken freezes the whole pipe.
  assign w_stall      = r_vld[N_LEVELS-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall & ~bus.set_en;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_busy       = |r_vld;

  assign bus.busy      = w_busy;
  assign bus.out_valid = r_vld[N_LEVELS-1];
  assign bus.out       = w_out;
  assign bus.set_ack   = w_set_ack;

  genvar gl, gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_in
      assign w_lvl_in[0][gi]                = bus.in[DW_DATA*gi +: DW_DATA];
      assign w_out[DW_DATA*gi +: DW_DATA]   = r_data[N_LEVELS-1][gi];
    end

    for (gl = 0; gl < N_LEVELS - 1; gl++) begin : g_wire
      for (gi = 0; gi < N; gi++) begin : g_pos
        localparam int SRC = src_idx(gl, gi);
        assign w_lvl_in[gl+1][gi] = r_data[gl][SRC];
      end
    end

    for (gl = 0; gl < N_LEVELS; gl++) begin : g_lvl
      for (gi = 0; gi < N_SW; gi++) begin : g_sw
        assign {w_lvl_out[gl][2*gi+1], w_lvl_out[gl][2*gi]} =
          switch2(r_cfg[(gl*N_SW+gi)*2 +: 2], w_lvl_in[gl][2*gi], w_lvl_in[gl][2*gi+1]);
      end
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
      // NOTE: data registers are reset too because the output bus must read 0 after reset.
      for (int k = 0; k < N_LEVELS; k++)
        for (int i = 0; i < N; i++)
          r_data[k][i] <= '0;
    end else if (!w_stall) begin
      r_vld <= {r_vld[N_LEVELS-2:0], w_accept};
      for (int k = 0; k < N_LEVELS; k++)
        for (int i = 0; i < N; i++)
          r_data[k][i] <= w_lvl_out[k][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_set_ack   = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.set_en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!bus.set_en)  w_state_nxt = S_IDLE;
        else if (!w_busy) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_IDLE;
        w_set_ack   = bus.set_en;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config only changes in LOAD, which is reachable only with the pipe empty.
  always_ff @(posedge clk) begin
    if (!reset)         r_cfg <= '0;
    else if (w_set_ack) r_cfg <= bus.route_signals;
  end

`ifdef DN_BENES_XFER_CNT_EN
  logic [31:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                                  r_xfer_cnt <= '0;
    else if (w_set_ack)                          r_xfer_cnt <= '0;
    else if (r_vld[N_LEVELS-1] & bus.out_ready)  r_xfer_cnt <= r_xfer_cnt + 32'd1;
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_dn_benes_pipe.sv
// Scoreboard bench for dn_benes_pipe: expected vectors are queued on accept and
// compared by a negedge monitor on every output transfer.
module tb_dn_benes_pipe;
  localparam int DW    = 8;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int NL    = 2 * LOG2N - 1;
  localparam int VW    = DW * N;
  localparam int CW    = NL * N;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dn_benes_pipe_if #(.DW_DATA(DW), .N(N), .LOG2N(LOG2N)) bus ();

`ifdef DN_BENES_XFER_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  dn_benes_pipe #(.DW_DATA(DW), .N(N), .LOG2N(LOG2N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DN_BENES_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int n_rx  = 0;
  logic [VW-1:0] exp_q [$];
  logic          mon_stall = 1'b0;
  logic [VW-1:0] mon_held;
  logic [VW-1:0] mon_exp;
  logic          tog_on = 1'b0;

  localparam logic [CW-1:0] CFG_ID    = '0;
  localparam logic [CW-1:0] CFG_CROSS = {8'h55, 32'h0};
  localparam logic [CW-1:0] CFG_MCAST = {38'h0, 2'b10};

  function automatic logic [VW-1:0] swap_pairs(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k += 2) begin
      r[DW*k +: DW]     = v[DW*(k+1) +: DW];
      r[DW*(k+1) +: DW] = v[DW*k +: DW];
    end
    return r;
  endfunction

  // Output monitor: scoreboard pop, stall stability, in_ready during stall, ack only when idle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mon_stall) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out !== mon_held) begin
          bad++;
          $display("FAIL stall_hold: out_valid=%b out=%h required out_valid=1 out=%h",
                   bus.out_valid, bus.out, mon_held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready: in_ready=%b required 0", bus.in_ready);
        end
        mon_stall = 1'b1;
        mon_held  = bus.out;
      end else begin
        mon_stall = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: out=%h with empty scoreboard", bus.out);
        end else begin
          mon_exp = exp_q.pop_front();
          n_rx++;
          if (bus.out !== mon_exp) begin
            bad++;
            $display("FAIL out_data: out=%h required %h", bus.out, mon_exp);
          end
        end
      end
      if (bus.set_ack === 1'b1) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL ack_while_busy: busy=%b required 0", bus.busy);
        end
      end
    end else begin
      mon_stall = 1'b0;
    end
  end

  // Presents one vector until accepted; the expected result is queued on the accepting cycle.
  task automatic send(input logic [VW-1:0] v, input logic [VW-1:0] e);
    bit done;
    done = 1'b0;
    bus.in       = v;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", bus.in_ready);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.busy === 1'b0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d busy=%b required 0/0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic load_cfg(input logic [CW-1:0] cfg);
    bit got;
    got = 1'b0;
    bus.route_signals = cfg;
    bus.set_en        = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL cfg_blocks_input: in_ready=%b required 0", bus.in_ready);
    end
    for (int c = 0; c < 100 && !got; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.set_ack === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.set_en   = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL set_ack_timeout: set_ack=%b required 1", bus.set_ack);
    end
    @(negedge clk);
    total++;
    if (bus.set_ack !== 1'b0) begin
      bad++;
      $display("FAIL set_ack_pulse: set_ack=%b required 0", bus.set_ack);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: %b required 0", bus.out_valid); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: %b required 0", bus.busy); end
    total++;
    if (bus.set_ack !== 1'b0) begin bad++; $display("FAIL rst_set_ack: %b required 0", bus.set_ack); end
    total++;
    if (bus.out !== '0) begin bad++; $display("FAIL rst_out: %h required 0", bus.out); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: %b required 1", bus.in_ready); end
`ifdef DN_BENES_XFER_CNT_EN
    total++;
    if (xfer_cnt !== 32'd0) begin bad++; $display("FAIL rst_xfer_cnt: %0d required 0", xfer_cnt); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity();
    int lat;
    lat = 0;
    send(64'h0807060504030201, 64'h0807060504030201);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) lat = c;
    end
    total++;
    if (lat != NL) begin
      bad++;
      $display("FAIL latency: %0d cycles required %0d", lat, NL);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_cross();
    load_cfg(CFG_CROSS);
    send(64'h0807060504030201, 64'h0708050603040102);
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_multicast();
    load_cfg(CFG_MCAST);
    send(64'h0807060504030201, 64'h0807060504030101);
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit pat [4];
    int rx0;
    logic [VW-1:0] v;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    load_cfg(CFG_ID);
    rx0    = n_rx;
    tog_on = 1'b1;
    fork
      begin
        int idx;
        idx = 0;
        while (tog_on) begin
          bus.out_ready = pat[idx % 4];
          idx++;
          @(posedge clk);
          #1;
        end
      end
    join_none
    for (int k = 0; k < 10; k++) begin
      v = {$urandom, $urandom};
      send(v, v);
    end
    bus.in_valid = 1'b0;
    wait_drain();
    tog_on = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    total++;
    if (n_rx - rx0 != 10) begin
      bad++;
      $display("FAIL stream_count: %0d vectors required 10", n_rx - rx0);
    end
`ifdef DN_BENES_XFER_CNT_EN
    total++;
    if (xfer_cnt !== 32'd10) begin bad++; $display("FAIL xfer_cnt: %0d required 10", xfer_cnt); end
`endif
  endtask

  task automatic test_cfg_traffic();
    logic [VW-1:0] v;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = {$urandom, $urandom};
      send(v, v);
    end
    // keep in_valid high with a vector that must never be accepted during the load
    bus.in = {$urandom, $urandom};
    load_cfg(CFG_CROSS);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL cfg_drain: %0d vectors pending at ack required 0", exp_q.size());
    end
    v = {$urandom, $urandom};
    send(v, swap_pairs(v));
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] v;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = {$urandom, $urandom};
      send(v, swap_pairs(v));
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_in_flight: busy=%b required 1", bus.busy); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: %b required 0", bus.out_valid); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: %b required 0", bus.busy); end
`ifdef DN_BENES_XFER_CNT_EN
    total++;
    if (xfer_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_xfer_cnt: %0d required 0", xfer_cnt); end
`endif
    @(posedge clk);
    #1;
    v = {$urandom, $urandom};
    send(v, v);
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.set_en        = 1'b0;
    bus.route_signals = '0;
    bus.in_valid      = 1'b0;
    bus.in            = '0;
    bus.out_ready     = 1'b1;
    test_reset();
    test_identity();
    test_cross();
    test_multicast();
    test_back_to_back();
    test_cfg_traffic();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
